// File: rtl/riscv_pkg.sv
// riscv_pkg: register-index width and RV32 load funct3 encodings shared by the writeback slice.
package riscv_pkg;
   localparam int REG_W = 5;
   typedef logic [REG_W-1:0] reg_idx_t;
   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } funct3_t;
endpackage

// File: rtl/wb_writer_if.sv
// wb_writer_if: ALU result, load response, load-issue and register-file write signals of the writeback stage.
interface wb_writer_if #(parameter int W = 31);
   import riscv_pkg::*;
   logic         alu_valid;
   reg_idx_t     alu_rd;
   logic [W:0]   alu_data;
   logic         ld_valid;
   logic         ld_ready;
   reg_idx_t     ld_rd;
   logic [W:0]   ld_data;
   logic [2:0]   ld_funct3;
   logic         lq_issue;
   reg_idx_t     lq_rd;
   logic [31:0]  busy;
   logic         wen;
   reg_idx_t     wadd;
   logic [W:0]   wdata;
   modport master (
      output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_funct3, lq_issue, lq_rd,
      input  ld_ready, busy, wen, wadd, wdata
   );
   modport slave (
      input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_funct3, lq_issue, lq_rd,
      output ld_ready, busy, wen, wadd, wdata
   );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: load-result buffer holding {rd, extended data}; DEPTH must be a power of two so pointers wrap naturally.
module wb_fifo import riscv_pkg::*; #(
   parameter int W     = 31,
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       push,
   input  reg_idx_t   push_rd,
   input  logic [W:0] push_data,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output reg_idx_t   head_rd,
   output logic [W:0] head_data
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   reg_idx_t      rd_mem   [DEPTH];
   logic [W:0]    data_mem [DEPTH];
   assign full      = count == CW'(DEPTH);
   assign empty     = count == '0;
   assign head_rd   = rd_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
         count  <= count + CW'(push) - CW'(pop);
      end
   end
   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]   <= push_rd;
         data_mem[wr_ptr] <= push_data;
      end
   end
endmodule

// File: rtl/wb_writer.sv
// wb_writer: writeback arbiter (ALU over buffered loads) with pending-load scoreboard.
// Optional WB_BYPASS_EN adds two read-port forwarding taps off the registered write.
module wb_writer import riscv_pkg::*; #(
   parameter int W     = 31,
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       nrst,
   wb_writer_if.slave bus
`ifdef WB_BYPASS_EN
   ,
   input  reg_idx_t   radd1,
   input  reg_idx_t   radd2,
   output logic       fwd1_hit,
   output logic       fwd2_hit,
   output logic [W:0] fwd1_data,
   output logic [W:0] fwd2_data
`endif
);
   logic        full, empty, push, pop;
   reg_idx_t    head_rd, wadd;
   logic [W:0]  head_data, ext, wdata;
   logic        wen;
   logic [31:0] busy, busy_nxt;
   assign push          = bus.ld_valid & ~full;
   assign pop           = ~bus.alu_valid & ~empty;
   assign bus.ld_ready  = ~full;
   assign bus.busy      = busy;
   assign bus.wen       = wen;
   assign bus.wadd      = wadd;
   assign bus.wdata     = wdata;
   always_comb begin
      ext = bus.ld_funct3 == LB  ? {{(W-7){bus.ld_data[7]}},  bus.ld_data[7:0]}  :
            bus.ld_funct3 == LH  ? {{(W-15){bus.ld_data[15]}}, bus.ld_data[15:0]} :
            bus.ld_funct3 == LBU ? {{(W-7){1'b0}},  bus.ld_data[7:0]}  :
            bus.ld_funct3 == LHU ? {{(W-15){1'b0}}, bus.ld_data[15:0]} :
            bus.ld_data;
   end
   wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .nrst      (nrst),
      .push      (push),
      .push_rd   (bus.ld_rd),
      .push_data (ext),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head_rd   (head_rd),
      .head_data (head_data)
   );
   // Set is applied after clear so a same-cycle issue to the popped rd keeps it pending.
   always_comb begin
      busy_nxt = busy;
      if (pop) busy_nxt[head_rd] = 1'b0;
      if (bus.lq_issue && bus.lq_rd != '0) busy_nxt[bus.lq_rd] = 1'b1;
   end
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         busy  <= '0;
         wen   <= 1'b0;
         wadd  <= '0;
         wdata <= '0;
      end else begin
         busy <= busy_nxt;
         if (bus.alu_valid) begin
            wen   <= bus.alu_rd != '0;
            wadd  <= bus.alu_rd;
            wdata <= bus.alu_data;
         end else if (pop) begin
            wen   <= head_rd != '0;
            wadd  <= head_rd;
            wdata <= head_data;
         end else begin
            wen <= 1'b0;
         end
      end
   end
`ifdef WB_BYPASS_EN
   assign fwd1_hit  = wen && wadd == radd1 && radd1 != '0;
   assign fwd2_hit  = wen && wadd == radd2 && radd2 != '0;
   assign fwd1_data = fwd1_hit ? wdata : '0;
   assign fwd2_data = fwd2_hit ? wdata : '0;
`endif
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed and randomized checks of wb_writer against a queue-based reference model.
module tb_wb_writer;
   localparam int W     = 31;
   localparam int DEPTH = 2;
   logic clk = 1'b0;
   logic nrst;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [4:0]  q_rd[$];
   logic [31:0] q_data[$];
   logic [31:0] m_busy;
   logic        e_wen;
   logic [4:0]  e_wadd;
   logic [31:0] e_wdata;
   wb_writer_if #(.W(W)) bus();
`ifdef WB_BYPASS_EN
   logic [4:0]  radd1 = '0, radd2 = '0;
   logic        fwd1_hit, fwd2_hit;
   logic [31:0] fwd1_data, fwd2_data;
`endif
   wb_writer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
`ifdef WB_BYPASS_EN
      ,
      .radd1     (radd1),
      .radd2     (radd2),
      .fwd1_hit  (fwd1_hit),
      .fwd2_hit  (fwd2_hit),
      .fwd1_data (fwd1_data),
      .fwd2_data (fwd2_data)
`endif
   );
   always #5 clk = ~clk;

   function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] d);
      case (f)
         3'b000:  return 32'($signed(d[7:0]));
         3'b001:  return 32'($signed(d[15:0]));
         3'b100:  return 32'(d[7:0]);
         3'b101:  return 32'(d[15:0]);
         default: return d;
      endcase
   endfunction

   task automatic idle();
      bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
      bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0; bus.ld_funct3 = 0;
      bus.lq_issue = 0; bus.lq_rd = 0;
   endtask

   task automatic model_reset();
      q_rd.delete(); q_data.delete();
      m_busy = 0; e_wen = 0; e_wadd = 0; e_wdata = 0;
   endtask

   // Advance one clock, updating the model from the inputs currently driven.
   task automatic tick();
      logic rdy, psh, pp;
      logic [4:0] r;
      rdy = q_rd.size() < DEPTH;
      psh = bus.ld_valid && rdy;
      pp  = !bus.alu_valid && q_rd.size() > 0;
      if (bus.alu_valid) begin
         e_wen = bus.alu_rd != 0; e_wadd = bus.alu_rd; e_wdata = bus.alu_data;
      end else if (pp) begin
         r = q_rd.pop_front(); e_wdata = q_data.pop_front();
         e_wen = r != 0; e_wadd = r; m_busy[r] = 1'b0;
      end else e_wen = 0;
      if (psh) begin
         q_rd.push_back(bus.ld_rd);
         q_data.push_back(ext(bus.ld_funct3, bus.ld_data));
      end
      if (bus.lq_issue && bus.lq_rd != 0) m_busy[bus.lq_rd] = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      nrst = 0; idle(); model_reset();
      #1;
      n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", bus.wen); end
      n_chk++; if (bus.wadd !== 5'd0) begin n_fail++; $display("FAIL reset_wadd: got %0d want 0", bus.wadd); end
      n_chk++; if (bus.wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.wdata); end
      n_chk++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
      n_chk++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 1", bus.ld_ready); end
      @(posedge clk); #1; nrst = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'h1234;
      tick(); idle();
      n_chk++; if ({bus.wen, bus.wadd, bus.wdata} !== {1'b1, 5'd5, 32'h1234})
         begin n_fail++; $display("FAIL alu_write: got wen=%b wadd=%0d wdata=%h want 1/5/00001234", bus.wen, bus.wadd, bus.wdata); end
      tick();
      n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL alu_one_cycle: got wen=%b want 0", bus.wen); end
   endtask

   task automatic test_sign_ext();
      bus.lq_issue = 1; bus.lq_rd = 7;
      tick(); idle();
      n_chk++; if (bus.busy[7] !== 1'b1) begin n_fail++; $display("FAIL busy_set7: got %b want 1", bus.busy[7]); end
      bus.ld_valid = 1; bus.ld_rd = 7; bus.ld_funct3 = 3'b000; bus.ld_data = 32'h0000_00F0;
      tick(); idle();
      n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got wen=%b want 0", bus.wen); end
      tick();
      n_chk++; if ({bus.wen, bus.wadd, bus.wdata} !== {1'b1, 5'd7, 32'hFFFF_FFF0})
         begin n_fail++; $display("FAIL lb_sext: got wen=%b wadd=%0d wdata=%h want 1/7/fffffff0", bus.wen, bus.wadd, bus.wdata); end
      n_chk++; if (bus.busy[7] !== 1'b0) begin n_fail++; $display("FAIL busy_clr7: got %b want 0", bus.busy[7]); end
      bus.ld_valid = 1; bus.ld_rd = 7; bus.ld_funct3 = 3'b101; bus.ld_data = 32'hABCD_8001;
      tick(); idle(); tick();
      n_chk++; if ({bus.wen, bus.wadd, bus.wdata} !== {1'b1, 5'd7, 32'h0000_8001})
         begin n_fail++; $display("FAIL lhu_zext: got wen=%b wadd=%0d wdata=%h want 1/7/00008001", bus.wen, bus.wadd, bus.wdata); end
   endtask

   task automatic test_collision();
      bus.lq_issue = 1; bus.lq_rd = 4;
      tick(); idle();
      bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'hAAAA_0003;
      bus.ld_valid = 1; bus.ld_rd = 4; bus.ld_funct3 = 3'b010; bus.ld_data = 32'hBBBB_0004;
      tick(); idle();
      n_chk++; if ({bus.wen, bus.wadd, bus.wdata} !== {1'b1, 5'd3, 32'hAAAA_0003})
         begin n_fail++; $display("FAIL coll_alu_first: got wen=%b wadd=%0d wdata=%h want 1/3/aaaa0003", bus.wen, bus.wadd, bus.wdata); end
      n_chk++; if (bus.busy[4] !== 1'b1) begin n_fail++; $display("FAIL coll_busy_held: got %b want 1", bus.busy[4]); end
      tick();
      n_chk++; if ({bus.wen, bus.wadd, bus.wdata} !== {1'b1, 5'd4, 32'hBBBB_0004})
         begin n_fail++; $display("FAIL coll_load_next: got wen=%b wadd=%0d wdata=%h want 1/4/bbbb0004", bus.wen, bus.wadd, bus.wdata); end
      n_chk++; if (bus.busy[4] !== 1'b0) begin n_fail++; $display("FAIL coll_busy_clr: got %b want 0", bus.busy[4]); end
   endtask

   task automatic test_full();
      logic [1:0] exp_rdy [3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = i;
         bus.ld_valid = 1; bus.ld_rd = 5'(10 + i); bus.ld_funct3 = 3'b010; bus.ld_data = 32'h100 + i;
         n_chk++; if (bus.ld_ready !== exp_rdy[i][0]) begin n_fail++; $display("FAIL full_ready%0d: got %b want %b", i, bus.ld_ready, exp_rdy[i][0]); end
         tick();
      end
      n_chk++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_end: got %b want 0", bus.ld_ready); end
      idle();
      for (int i = 0; i < 2; i++) begin
         tick();
         n_chk++; if ({bus.wen, bus.wadd, bus.wdata} !== {1'b1, 5'(10 + i), 32'h100 + i})
            begin n_fail++; $display("FAIL drain%0d: got wen=%b wadd=%0d wdata=%h want 1/%0d/%h", i, bus.wen, bus.wadd, bus.wdata, 10 + i, 32'h100 + i); end
      end
      n_chk++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b want 1", bus.ld_ready); end
      tick();
      n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL dropped_load: got wen=%b want 0", bus.wen); end
   endtask

   task automatic test_reg0_busy();
      bus.lq_issue = 1; bus.lq_rd = 9;
      tick(); idle();
      bus.ld_valid = 1; bus.ld_rd = 9; bus.ld_data = 32'h99; bus.ld_funct3 = 3'b010;
      tick(); idle();
      bus.ld_valid = 1; bus.ld_rd = 0; bus.ld_data = 32'h55; bus.ld_funct3 = 3'b010;
      bus.lq_issue = 1; bus.lq_rd = 9;
      tick(); idle();
      n_chk++; if ({bus.wen, bus.wadd} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL pop9: got wen=%b wadd=%0d want 1/9", bus.wen, bus.wadd); end
      n_chk++; if (bus.busy[9] !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b want 1", bus.busy[9]); end
      bus.lq_issue = 1; bus.lq_rd = 0;
      tick(); idle();
      n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL rd0_wen: got %b want 0", bus.wen); end
      n_chk++; if (bus.busy[0] !== 1'b0) begin n_fail++; $display("FAIL busy0: got %b want 0", bus.busy[0]); end
      tick();
      n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL rd0_consumed: got wen=%b want 0", bus.wen); end
   endtask

   task automatic test_reset_mid();
      bus.lq_issue = 1; bus.lq_rd = 4;
      tick();
      bus.lq_rd = 9;
      tick(); idle();
      n_chk++; if (bus.busy !== 32'h0000_0210) begin n_fail++; $display("FAIL mid_busy: got %h want 00000210", bus.busy); end
      for (int i = 0; i < 2; i++) begin
         bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'h77;
         bus.ld_valid = 1; bus.ld_rd = 5'(20 + i); bus.ld_data = 32'h200 + i; bus.ld_funct3 = 3'b010;
         tick();
      end
      idle();
      n_chk++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", bus.ld_ready); end
      #2 nrst = 0; model_reset();
      #1;
      n_chk++; if ({bus.wen, bus.busy, bus.ld_ready} !== {1'b0, 32'd0, 1'b1})
         begin n_fail++; $display("FAIL mid_reset: got wen=%b busy=%h ld_ready=%b want 0/0/1", bus.wen, bus.busy, bus.ld_ready); end
      @(posedge clk); #1; nrst = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_chk++; if (bus.wen !== 1'b0) begin n_fail++; $display("FAIL post_reset%0d: got wen=%b wadd=%0d want 0", i, bus.wen, bus.wadd); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.alu_valid = ($urandom % 3) == 0;
         bus.alu_rd    = 5'($urandom);
         bus.alu_data  = $urandom;
         bus.ld_valid  = $urandom % 2;
         bus.ld_rd     = 5'($urandom);
         bus.ld_data   = $urandom;
         bus.ld_funct3 = 3'($urandom);
         bus.lq_issue  = ($urandom % 10) < 3;
         bus.lq_rd     = 5'($urandom);
         n_chk++; if (bus.ld_ready !== (q_rd.size() < DEPTH))
            begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", i, bus.ld_ready, q_rd.size() < DEPTH); end
         tick();
         n_chk++; if (bus.wen !== e_wen) begin n_fail++; $display("FAIL rnd_wen@%0d: got %b want %b", i, bus.wen, e_wen); end
         if (e_wen) begin
            n_chk++; if ({bus.wadd, bus.wdata} !== {e_wadd, e_wdata})
               begin n_fail++; $display("FAIL rnd_write@%0d: got %0d/%h want %0d/%h", i, bus.wadd, bus.wdata, e_wadd, e_wdata); end
         end
         n_chk++; if (bus.busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy@%0d: got %h want %h", i, bus.busy, m_busy); end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_sign_ext();
      test_collision();
      test_full();
      test_reg0_busy();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
